mem_port_arbiter: RTL and testbench

- Shares the single memory port (en, rw, mfc handshake) between the CPU's memory-using FSMs: fetch, load and store.
- Grants one requester at a time, round-robin, and forwards its en/rw to memory.
- Routes mfc back only to the granted requester.
- Enforces the full en/mfc four-phase release before the next grant and flags memory timeouts.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one en/rw/mfc memory port between the fetch,
// load and store FSMs. Round-robin grant, mfc routed only to the owner,
// full four-phase release before the next grant, sticky timeout flag.
module mem_port_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_en,
  input  logic [NREQ-1:0] req_rw,
  input  logic            mem_mfc,
  input  logic            err_clr,
  output logic            mem_en,
  output logic            mem_rw,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] req_mfc,
  output logic            busy,
  output logic            timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t          state;
  logic [IW-1:0]   last;       // most recently served requester
  logic [IW-1:0]   own;        // index of current owner
  logic [CNTW-1:0] cnt;        // ACCESS cycles without mfc
  logic            timed_out;  // current transaction ended by timeout

  logic            sel_vld;
  logic [IW-1:0]   sel;
  logic [NREQ-1:0] sel_oh;

  // Round-robin pick: first requester after the last one served, wrapping
  always_comb begin
    sel_vld = 1'b0;
    sel     = last;
    sel_oh  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last) + k) % NREQ;
      if (!sel_vld && req_en[idx]) begin
        sel_vld     = 1'b1;
        sel         = IW'(idx);
        sel_oh[idx] = 1'b1;
      end
    end
  end

  // mfc goes back only to the owner; grant is all-zero while idle
  for (genvar i = 0; i < NREQ; i++) begin : g_mfc
    assign req_mfc[i] = mem_mfc & grant[i];
  end

  assign busy = (state != IDLE);

  // Port FSM; all outputs registered. err_clr is applied first so a
  // coinciding timeout set overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      mem_en      <= 1'b0;
      mem_rw      <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      last        <= IW'(NREQ - 1);
      own         <= '0;
      timed_out   <= 1'b0;
    end else begin
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            grant     <= sel_oh;
            own       <= sel;
            mem_en    <= 1'b1;
            mem_rw    <= req_rw[sel];
            cnt       <= '0;
            timed_out <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // mfc is checked first so it beats a same-cycle timeout
          if (mem_mfc) begin
            mem_en <= req_en[own];
            state  <= RELEASE;
          end else if (!req_en[own]) begin
            mem_en <= 1'b0;
            state  <= RELEASE;
          end else if (cnt == CNTW'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            timed_out   <= 1'b1;
            mem_en      <= 1'b0;
            state       <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          // Wait for both sides to drop before freeing the port
          if (!req_en[own] && !mem_mfc) begin
            grant  <= '0;
            mem_en <= 1'b0;
            last   <= own;
            state  <= IDLE;
          end else begin
            mem_en <= req_en[own] & ~timed_out;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_mem_port_arbiter;

  logic       clk, rst;
  logic [2:0] req_en, req_rw;
  logic       mem_mfc, err_clr;
  logic       mem_en, mem_rw, busy, timeout_err;
  logic [2:0] grant, req_mfc;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.NREQ(3), .TIMEOUT(15), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_rw(req_rw),
    .mem_mfc(mem_mfc), .err_clr(err_clr), .mem_en(mem_en),
    .mem_rw(mem_rw), .grant(grant), .req_mfc(req_mfc),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_en = '0; req_rw = '0; mem_mfc = 1'b0; err_clr = 1'b0;
    nedge();
    // reset state
    chk("rst_en",    32'(mem_en), 0);
    chk("rst_rw",    32'(mem_rw), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_err",   32'(timeout_err), 0);
    chk("rst_mfc",   32'(req_mfc), 0);
    rst = 1'b0;
    nedge();
    chk("idle_en", 32'(mem_en), 0);

    // 1: single read by requester 0
    req_en = 3'b001; req_rw = 3'b001;
    nedge();
    chk("t1_grant", 32'(grant), 3'b001);
    chk("t1_en",    32'(mem_en), 1);
    chk("t1_rw",    32'(mem_rw), 1);
    chk("t1_busy",  32'(busy), 1);
    nedge(); nedge();
    mem_mfc = 1'b1;
    #1 chk("t1_rmfc_on", 32'(req_mfc), 3'b001);
    nedge();
    chk("t1_rel_en", 32'(mem_en), 1);
    req_en = 3'b000;
    nedge();
    chk("t1_en_drop", 32'(mem_en), 0);
    chk("t1_hold",    32'(busy), 1);
    mem_mfc = 1'b0;
    #1 chk("t1_rmfc_off", 32'(req_mfc), 0);
    nedge();
    chk("t1_idle_grant", 32'(grant), 0);
    chk("t1_idle_busy",  32'(busy), 0);
    req_rw = 3'b000;

    // 2: contention, fresh rotation after reset
    rst = 1'b1; #1 rst = 1'b0;
    req_en = 3'b111;
    begin
      logic [2:0] order [4];
      order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
      for (int n = 0; n < 4; n++) begin
        nedge();
        chk($sformatf("t2_grant%0d", n), 32'(grant), 32'(order[n]));
        chk($sformatf("t2_en%0d", n), 32'(mem_en), 1);
        mem_mfc = 1'b1;
        nedge();
        req_en = 3'b111 & ~order[n];
        mem_mfc = 1'b0;
        nedge();
        chk($sformatf("t2_gap_en%0d", n), 32'(mem_en), 0);
        chk($sformatf("t2_gap_gnt%0d", n), 32'(grant), 0);
        req_en = 3'b111;
      end
    end
    req_en = 3'b000;
    nedge();

    // 3: write latch on requester 2 (last served was 0)
    req_en = 3'b100; req_rw = 3'b000;
    nedge();
    chk("t3_grant", 32'(grant), 3'b100);
    chk("t3_rw0",   32'(mem_rw), 0);
    req_rw = 3'b100;
    nedge();
    chk("t3_rw_held1", 32'(mem_rw), 0);
    mem_mfc = 1'b1;
    #1 chk("t3_rmfc", 32'(req_mfc), 3'b100);
    nedge();
    chk("t3_rw_held2", 32'(mem_rw), 0);
    req_en = 3'b000; mem_mfc = 1'b0;
    nedge();
    chk("t3_idle", 32'(busy), 0);
    req_rw = 3'b000;

    // 4: timeout on requester 0
    req_en = 3'b001;
    nedge();
    chk("t4_grant", 32'(grant), 3'b001);
    begin
      int high = 1;
      for (int n = 0; n < 15; n++) begin
        nedge();
        if (mem_en !== 1'b1) high = 0;
      end
      chk("t4_en_16cyc", 32'(high), 1);
    end
    nedge();
    chk("t4_en_fall", 32'(mem_en), 0);
    chk("t4_err",     32'(timeout_err), 1);
    chk("t4_busy",    32'(busy), 1);
    nedge();
    chk("t4_en_stays0", 32'(mem_en), 0);
    req_en = 3'b000;
    nedge();
    chk("t4_idle",       32'(busy), 0);
    chk("t4_err_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    nedge();
    chk("t4_err_clr", 32'(timeout_err), 0);
    err_clr = 1'b0;

    // 5: abort by requester 1 (last served was 0)
    req_en = 3'b010;
    nedge();
    chk("t5_grant", 32'(grant), 3'b010);
    req_en = 3'b000;
    nedge();
    chk("t5_en", 32'(mem_en), 0);
    mem_mfc = 1'b1;
    nedge();
    chk("t5_wait_mfc", 32'(busy), 1);
    chk("t5_rmfc",     32'(req_mfc), 3'b010);
    mem_mfc = 1'b0;
    nedge();
    chk("t5_idle", 32'(busy), 0);
    chk("t5_err",  32'(timeout_err), 0);

    // 6: async reset mid-ACCESS (last served was 1 -> requester 2 wins)
    req_en = 3'b110;
    nedge();
    chk("t6_grant", 32'(grant), 3'b100);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_en",    32'(mem_en), 0);
    chk("t6_async_grant", 32'(grant), 0);
    chk("t6_async_busy",  32'(busy), 0);
    nedge();
    rst = 1'b0;
    nedge();
    chk("t6_restart", 32'(grant), 3'b010);
    req_en = 3'b000;
    nedge();
    nedge();
    chk("t6_final_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
